// File: rtl/mult_pkg.sv
// Shared constants and elaboration-time helpers for the 15:4-counter multiplier tree.
package mult_pkg;

   localparam int unsigned COUNTER_IN  = 15;
   localparam int unsigned COUNTER_OUT = 4;

   // Row height after one reduction stage. Tall stages use 15:4 counters. Heights 3-4 use
   // full adders.
   function automatic int unsigned next_height(input int unsigned h);
      if (h > 4) begin
         return COUNTER_OUT * ((h + COUNTER_IN - 1) / COUNTER_IN);
      end else if (h > 2) begin
         return h - h / 3;
      end
      return h;
   endfunction

   // Maximum column height entering the given stage (stage 0 holds the raw partial products).
   function automatic int unsigned dadda_height(input int unsigned width,
                                                input int unsigned stage);
      int unsigned h;
      h = width;
      for (int unsigned s = 0; s < stage; s++) begin
         h = next_height(h);
      end
      return h;
   endfunction

   function automatic int unsigned num_stages(input int unsigned width);
      int unsigned h;
      int unsigned n;
      h = width;
      n = 0;
      while (h > 2) begin
         h = next_height(h);
         n++;
      end
      return n;
   endfunction

   function automatic int unsigned num_columns(input int unsigned width);
      return 2 * width - 1;
   endfunction

endpackage

// File: rtl/counter_15_4.sv
// 15:4 counter: population count of up to fifteen equally weighted bits.
module counter_15_4
   import mult_pkg::*;
(
   input  logic [COUNTER_IN-1:0]  in,
   output logic [COUNTER_OUT-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < COUNTER_IN; i++) begin
         cnt = cnt + COUNTER_OUT'(in[i]);
      end
   end

endmodule

// File: rtl/dadda_mult_15_4.sv
// Unsigned WIDTH x WIDTH multiplier: 15:4-counter reduction tree, final CPA, registered product.
module dadda_mult_15_4
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned PW         = num_columns(WIDTH) + 1;
   localparam int unsigned NUM_STAGES = num_stages(WIDTH);

   if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
      $error("dadda_mult_15_4: WIDTH must be 8, 16, 32 or 64");
   end

   logic [PW-1:0] product_d;
   logic [PW-1:0] product_q;

   // Each stage holds its columns as rows: bit w of every row has weight w.
   for (genvar s = 0; s <= NUM_STAGES; s++) begin : g_stage
      localparam int unsigned H = dadda_height(WIDTH, s);
      logic [PW-1:0] rows [H];

      if (s == 0) begin : g_pp
         for (genvar i = 0; i < WIDTH; i++) begin : g_row
            assign rows[i] = PW'(a & {WIDTH{b[i]}}) << i;
         end
      end else begin : g_red
         localparam int unsigned HP = dadda_height(WIDTH, s - 1);

         if (HP > 4) begin : g_cnt
            localparam int unsigned G = (HP + COUNTER_IN - 1) / COUNTER_IN;
            for (genvar k = 0; k < G; k++) begin : g_grp
               for (genvar w = 0; w < PW; w++) begin : g_col
                  logic [COUNTER_IN-1:0]  cin;
                  logic [COUNTER_OUT-1:0] cnt;

                  for (genvar i = 0; i < COUNTER_IN; i++) begin : g_in
                     if (k * COUNTER_IN + i < HP) begin : g_used
                        assign cin[i] = g_stage[s-1].rows[k*COUNTER_IN+i][w];
                     end else begin : g_tie
                        assign cin[i] = 1'b0;
                     end
                  end

                  counter_15_4 u_counter (
                     .in  (cin),
                     .cnt (cnt)
                  );

                  // Count bit j lands in row 4k+j at weight w+j; weights past the product drop.
                  for (genvar j = 0; j < COUNTER_OUT; j++) begin : g_out
                     if (w + j < PW) begin : g_keep
                        assign rows[COUNTER_OUT*k+j][w+j] = cnt[j];
                     end else begin : g_drop
                        logic unused_carry;
                        assign unused_carry = cnt[j];
                     end
                     if (w < j) begin : g_low
                        assign rows[COUNTER_OUT*k+j][w] = 1'b0;
                     end
                  end
               end
            end
         end else begin : g_csa
            localparam int unsigned G = HP / 3;
            for (genvar k = 0; k < G; k++) begin : g_fa
               logic [PW-1:0] x, y, z;
               assign x = g_stage[s-1].rows[3*k];
               assign y = g_stage[s-1].rows[3*k+1];
               assign z = g_stage[s-1].rows[3*k+2];
               assign rows[2*k]   = x ^ y ^ z;
               assign rows[2*k+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
            for (genvar r = 3 * G; r < HP; r++) begin : g_pass
               assign rows[r-G] = g_stage[s-1].rows[r];
            end
         end
      end
   end

   // The product always fits in PW bits, so the CPA carry-out is dropped.
   assign product_d = g_stage[NUM_STAGES].rows[0] + g_stage[NUM_STAGES].rows[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product_q <= '0;
      end else begin
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_dadda_mult_15_4.sv
// Self-checking bench: all legal widths against plain a*b, plus an exhaustive counter_15_4 sweep.
module tb_dadda_mult_15_4;

   logic clk = 1'b0;
   logic rst;

   logic [7:0]   a8,  b8;
   logic [15:0]  p8;
   logic [15:0]  a16, b16;
   logic [31:0]  p16;
   logic [31:0]  a32, b32;
   logic [63:0]  p32;
   logic [63:0]  a64, b64;
   logic [127:0] p64;
   logic [14:0]  cnt_in;
   logic [3:0]   cnt_out;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   dadda_mult_15_4 #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .product(p8)
   );
   dadda_mult_15_4 #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .a(a16), .b(b16), .product(p16)
   );
   dadda_mult_15_4 #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .a(a32), .b(b32), .product(p32)
   );
   dadda_mult_15_4 #(.WIDTH(64)) u_dut64 (
      .clk(clk), .rst(rst), .a(a64), .b(b64), .product(p64)
   );
   counter_15_4 u_counter (
      .in  (cnt_in),
      .cnt (cnt_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] corner_a [4] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
   logic [15:0] corner_b [4] = '{16'h1234, 16'hBEEF, 16'h8000, 16'h0001};
   logic [31:0] corner_p [4] = '{32'h0, 32'h0000BEEF, 32'h40000000, 32'h0000FFFF};
   logic [15:0] bb_a [3] = '{16'd3, 16'h00FF, 16'hAAAA};
   logic [15:0] bb_b [3] = '{16'd5, 16'h0101, 16'h5555};
   logic [31:0] bb_p [3] = '{32'd15, 32'h0000FFFF, 32'h38E31C72};

   logic [15:0]  r8;
   logic [31:0]  r16;
   logic [63:0]  r32;
   logic [127:0] r64;

   initial begin
      rst = 1'b1;
      a8 = '0; b8 = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;
      a16 = 16'hFFFF; b16 = 16'hFFFF;
      cnt_in = '0;

      // Reset holds the register at zero across clock edges.
      repeat (3) step();
      check_eq("reset_hold_16", 128'(p16), 128'h0);
      check_eq("reset_hold_64", p64, 128'h0);

      rst = 1'b0;
      step();
      check_eq("reset_release", 128'(p16), 128'hFFFE0001);

      // Asynchronous assertion clears the product without a clock edge.
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_reset", 128'(p16), 128'h0);
      step();
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         a16 = corner_a[i];
         b16 = corner_b[i];
         step();
         check_eq($sformatf("corner_%0d", i), 128'(p16), 128'(corner_p[i]));
      end

      a8  = 8'hFF;  b8  = 8'hFF;
      a32 = '1;     b32 = '1;
      a64 = '1;     b64 = '1;
      step();
      check_eq("max_8",  128'(p8),  128'hFE01);
      check_eq("max_32", 128'(p32), 128'hFFFFFFFE00000001);
      check_eq("max_64", p64,       128'hFFFFFFFFFFFFFFFE0000000000000001);

      for (int i = 0; i < 3; i++) begin
         a16 = bb_a[i];
         b16 = bb_b[i];
         step();
         check_eq($sformatf("b2b_%0d", i), 128'(p16), 128'(bb_p[i]));
      end

      for (int n = 0; n < 1000; n++) begin
         a8  = 8'($urandom);           b8  = 8'($urandom);
         a16 = 16'($urandom);          b16 = 16'($urandom);
         a32 = $urandom;               b32 = $urandom;
         a64 = {$urandom, $urandom};   b64 = {$urandom, $urandom};
         r8  = 16'(a8)   * 16'(b8);
         r16 = 32'(a16)  * 32'(b16);
         r32 = 64'(a32)  * 64'(b32);
         r64 = 128'(a64) * 128'(b64);
         step();
         check_eq("rand_8",  128'(p8),  128'(r8));
         check_eq("rand_16", 128'(p16), 128'(r16));
         check_eq("rand_32", 128'(p32), 128'(r32));
         check_eq("rand_64", p64,       r64);
      end

      cnt_in = 15'h7FFF;
      #1;
      check_eq("cnt_all_ones", 128'(cnt_out), 128'd15);
      cnt_in = 15'h0000;
      #1;
      check_eq("cnt_zero", 128'(cnt_out), 128'd0);
      for (int p = 0; p < 32768; p++) begin
         cnt_in = 15'(p);
         #1;
         check_eq("cnt_sweep", 128'(cnt_out), 128'($countones(cnt_in)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
